// File: rtl/uart_rx_mmio.sv
// UART receiver with a small receive FIFO and a memory-mapped CPU read port.
// The serial line is oversampled 16x. Each received byte is pushed into the FIFO.
// The CPU reads the byte at DATA_ADDR and reads the status byte at STAT_ADDR.
module uart_rx_mmio #(
    parameter logic [10:0] DATA_ADDR  = 11'd102,
    parameter logic [10:0] STAT_ADDR  = 11'd103,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxclk_en,
    input  logic        rx,
    input  logic [10:0] m_addr,
    input  logic        m_rd,
    input  logic        m_en,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        rx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          r_rxMeta;
    logic          r_rxSync;
    state_t        r_state;
    logic [3:0]    r_tick;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          r_frameErr;

    logic       w_frameDone;
    logic       w_stopOk;
    logic       w_stopBad;
    logic       w_dataSel;
    logic       w_statSel;
    logic       w_rdHit;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_overrunSet;
    logic       w_statRead;
    logic [7:0] w_status;

    // The stop bit is sampled on the last tick of STOP. Push and error decisions are made on that same edge.
    assign w_frameDone  = (r_state == STOP) && rxclk_en && (r_tick == 4'd15);
    assign w_stopOk     = w_frameDone && r_rxSync;
    assign w_stopBad    = w_frameDone && !r_rxSync;
    assign w_dataSel    = (m_addr == DATA_ADDR);
    assign w_statSel    = (m_addr == STAT_ADDR);
    assign w_rdHit      = (w_dataSel || w_statSel) && m_rd && m_en;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_COUNT);
    assign w_pop        = w_rdHit && w_dataSel && !w_empty;
    assign w_push       = w_stopOk && (!w_full || w_pop);
    assign w_overrunSet = w_stopOk && w_full && !w_pop;
    assign w_statRead   = w_rdHit && w_statSel;
    assign w_status     = {5'b0, r_overrun, r_frameErr, !w_empty};

    assign rd_hit = w_rdHit;
    assign rx_irq = !w_empty;

    // Select read data from the address decode. An unaddressed bus or an empty FIFO reads as zero.
    always_comb begin
        rd_data = 8'h00;
        if (w_rdHit) begin
            if (w_dataSel) begin
                rd_data = w_empty ? 8'h00 : r_mem[r_rdPtr];
            end else begin
                rd_data = w_status;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous line. It resets to the idle-high level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Receive FSM. The start bit is checked mid-bit, and each data bit is then sampled every 16 ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_tick   <= 4'd0;
            r_bitCnt <= 3'd0;
            r_shift  <= 8'h00;
        end else if (rxclk_en) begin
            case (r_state)
                IDLE: begin
                    if (!r_rxSync) begin
                        r_state <= START;
                        r_tick  <= 4'd0;
                    end
                end
                START: begin
                    if (r_tick == 4'd7) begin
                        if (!r_rxSync) begin
                            r_state  <= DATA;
                            r_tick   <= 4'd0;
                            r_bitCnt <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 4'd1;
                    end
                end
                DATA: begin
                    if (r_tick == 4'd15) begin
                        r_shift <= {r_rxSync, r_shift[7:1]};
                        r_tick  <= 4'd0;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end else begin
                        r_tick <= r_tick + 4'd1;
                    end
                end
                STOP: begin
                    if (r_tick == 4'd15) begin
                        r_state <= IDLE;
                        r_tick  <= 4'd0;
                    end else begin
                        r_tick <= r_tick + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // FIFO storage. It is written only on a push, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ONE_PTR;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ONE_PTR;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags. A status read clears them, but a new error on the same edge still sets them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_overrun  <= w_overrunSet || (r_overrun && !w_statRead);
            r_frameErr <= w_stopBad || (r_frameErr && !w_statRead);
        end
    end

endmodule
